// File: rtl/uart_loop_fifo.sv
// -----------------------------------------------------------------------------
// uart_loop_fifo
//
// Byte buffer sitting between uart_rx and uart_tx in the UART loopback path.
// Received bytes arrive as one-cycle strobes and are queued in a circular
// FIFO. A three-state drain FSM hands them to uart_tx one at a time using a
// level-held request (o_send_en) and the transmitter's busy flag.
//
// A byte leaves the FIFO only when its transmission has completed (busy seen
// high and then low again). Its slot therefore cannot be reused while the
// byte is still being sent.
//
// Ports
//   i_sys_clk    system clock
//   i_rst_n      asynchronous active-low reset
//   i_recv_en    one-cycle strobe: i_recv_data holds a valid byte
//   i_recv_data  received byte
//   o_send_en    transmit request to uart_tx (level)
//   o_send_data  byte to transmit, stable while o_send_en=1
//   i_send_busy  uart_tx busy flag
//   o_fifo_cnt   current occupancy, 0..DEPTH
//   o_empty      occupancy is zero
//   o_full       occupancy is DEPTH
//   o_overflow   sticky: a byte was dropped because the FIFO was full
//   i_clr_ovf    one-cycle clear for o_overflow (a coincident drop wins)
// -----------------------------------------------------------------------------
module uart_loop_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_recv_en,
  input  logic [DATA_W-1:0] i_recv_data,
  output logic              o_send_en,
  output logic [DATA_W-1:0] o_send_data,
  input  logic              i_send_busy,
  output logic [CNT_W-1:0]  o_fifo_cnt,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow,
  input  logic              i_clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Storage and bookkeeping
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              empty_r;
  logic              full_r;
  logic              overflow_r;

  // Drain FSM
  state_t            state_r;
  logic              send_en_r;
  logic [DATA_W-1:0] send_data_r;

  // Handshake events
  logic              push_s;
  logic              pop_s;

  // The full decision uses the registered flag, so a byte arriving while full
  // is dropped even if a pop completes in the same cycle.
  assign push_s = i_recv_en & ~full_r;

  // A pop happens only when the transmitter drops busy after accepting the
  // byte, i.e. on the DONE -> IDLE transition.
  assign pop_s  = (state_r == ST_DONE) & ~i_send_busy;

  // Next-state occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Byte storage; contents are deliberately left out of reset.
  always_ff @(posedge i_sys_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_recv_data;
    end
  end

  // Write pointer; wraps naturally because DEPTH is a power of two.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= PTR_W'(0);
    end else if (push_s) begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer; advances only when a transmission has completed.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_r <= PTR_W'(0);
    end else if (pop_s) begin
      rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Occupancy counter and status flags, all taken from the next-state count
  // so they agree with each other in every cycle.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r <= CNT_W'(0);
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == CNT_W'(0));
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
    end
  end

  // Sticky overflow flag; a dropped byte takes priority over a clear.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_r <= 1'b0;
    end else if (i_recv_en && full_r) begin
      overflow_r <= 1'b1;
    end else if (i_clr_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Drain FSM with registered request and data. IDLE waits for data and an
  // idle transmitter, REQ waits for the transmitter to take the byte, and
  // DONE waits for it to finish. Leaving DONE drops the request for at least
  // one cycle, because IDLE can only raise it again on the following edge.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      send_en_r   <= 1'b0;
      send_data_r <= DATA_W'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_r && !i_send_busy) begin
            send_data_r <= mem_r[rd_ptr_r];
            send_en_r   <= 1'b1;
            state_r     <= ST_REQ;
          end else begin
            send_en_r   <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_REQ: begin
          send_en_r <= 1'b1;
          if (i_send_busy) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_DONE: begin
          if (!i_send_busy) begin
            send_en_r <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            send_en_r <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        default: begin
          send_en_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_send_en   = send_en_r;
  assign o_send_data = send_data_r;
  assign o_fifo_cnt  = count_r;
  assign o_empty     = empty_r;
  assign o_full      = full_r;
  assign o_overflow  = overflow_r;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_loop_fifo
//
// Testbench for uart_loop_fifo. Directed stimulus pushes each byte that should
// come out into a queue of expected bytes. A separate monitor pops that queue
// on every new transmit request and compares the byte. A uart_tx model
// answers requests with a configurable busy pulse, or it can hold busy high
// (stall) or leave busy to the test sequence (manual).
// -----------------------------------------------------------------------------
module tb_uart_loop_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 5;

  localparam int TX_AUTO   = 0;
  localparam int TX_STALL  = 1;
  localparam int TX_MANUAL = 2;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              recv_en   = 1'b0;
  logic [DATA_W-1:0] recv_data = 8'h00;
  logic              send_busy = 1'b0;
  logic              clr_ovf   = 1'b0;
  logic              send_en;
  logic [DATA_W-1:0] send_data;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              empty;
  logic              full;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_mode  = TX_AUTO;
  int tx_hold  = 3;
  int peak_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  uart_loop_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .i_sys_clk   (clk),
    .i_rst_n     (rst_n),
    .i_recv_en   (recv_en),
    .i_recv_data (recv_data),
    .o_send_en   (send_en),
    .o_send_data (send_data),
    .i_send_busy (send_busy),
    .o_fifo_cnt  (fifo_cnt),
    .o_empty     (empty),
    .o_full      (full),
    .o_overflow  (overflow),
    .i_clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each new request must carry the oldest expected byte, and the
  // byte must stay stable while the request is held.
  initial begin : monitor
    logic prev_en = 1'b0;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (send_en && !prev_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_request: got data 0x%0h, expected no request", send_data);
        end else begin
          e = exp_q.pop_front();
          check("send_data", send_data, e);
        end
        held = send_data;
      end else if (send_en && prev_en) begin
        check("send_data_stable", send_data, held);
      end
      prev_en = send_en;
    end
  end

  // uart_tx model
  initial begin : tx_model
    forever begin
      @(negedge clk);
      case (tx_mode)
        TX_AUTO: begin
          if (send_en && !send_busy) begin
            send_busy = 1'b1;
            repeat (tx_hold) @(negedge clk);
            send_busy = 1'b0;
          end else begin
            send_busy = 1'b0;
          end
        end
        TX_STALL: send_busy = 1'b1;
        default: ;
      endcase
    end
  end

  // Peak occupancy tracker
  initial begin : peak_mon
    forever begin
      @(negedge clk);
      if (int'(fifo_cnt) > peak_cnt) peak_cnt = int'(fifo_cnt);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // One-cycle receive strobe; called just after a negedge, returns at the
  // next one. Back-to-back calls give consecutive strobes.
  task automatic strobe(input logic [DATA_W-1:0] d, input bit kept);
    recv_en   = 1'b1;
    recv_data = d;
    if (kept) exp_q.push_back(d);
    @(negedge clk);
    recv_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && empty && !send_en && !send_busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_en(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (send_en) break;
      @(negedge clk);
    end
    check(name, 32'(send_en), 32'd1);
  endtask

  initial begin : stim
    bit any_en;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_send_en", 32'(send_en), 32'd0);
    check("rst_send_data", 32'(send_data), 32'h00);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_cnt", 32'(fifo_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Single byte with exact latency
    strobe(8'h55, 1'b1);
    check("t1_empty_n1", 32'(empty), 32'd0);
    check("t1_send_en_n1", 32'(send_en), 32'd0);
    check("t1_cnt_n1", 32'(fifo_cnt), 32'd1);
    @(negedge clk);
    check("t1_send_en_n2", 32'(send_en), 32'd1);
    check("t1_send_data_n2", 32'(send_data), 32'h55);
    wait_idle("t1_drain", 50);
    check("t1_send_en_end", 32'(send_en), 32'd0);
    check("t1_empty_end", 32'(empty), 32'd1);
    check("t1_cnt_end", 32'(fifo_cnt), 32'd0);

    // 2. Burst of 10 while the transmitter is slow
    tx_hold  = 20;
    peak_cnt = 0;
    for (int i = 1; i <= 10; i++) strobe(8'(i), 1'b1);
    wait_idle("t2_drain", 400);
    check("t2_peak_cnt", 32'(peak_cnt), 32'd10);
    check("t2_overflow", 32'(overflow), 32'd0);

    // 3. Overflow with the transmitter held busy
    tx_mode = TX_STALL;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 18; i++) strobe(8'(i), i < 16);
    check("t3_full", 32'(full), 32'd1);
    check("t3_cnt", 32'(fifo_cnt), 32'd16);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_send_en_stalled", 32'(send_en), 32'd0);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t3_ovf_cleared", 32'(overflow), 32'd0);
    clr_ovf = 1'b1;
    strobe(8'h12, 1'b0);
    clr_ovf = 1'b0;
    check("t3_ovf_set_wins", 32'(overflow), 32'd1);
    check("t3_cnt_after_drop", 32'(fifo_cnt), 32'd16);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    tx_hold = 3;
    tx_mode = TX_AUTO;
    wait_idle("t3_drain", 300);
    check("t3_cnt_end", 32'(fifo_cnt), 32'd0);
    check("t3_overflow_end", 32'(overflow), 32'd0);

    // 4. Wrap-around: 40 bytes in bursts of 5
    tx_hold = 2;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 5; k++) strobe(8'(8'h20 + b * 5 + k), 1'b1);
      wait_idle("t4_drain", 120);
    end

    // 5. Push coincident with pop at count 3
    tx_mode = TX_MANUAL;
    @(negedge clk);
    send_busy = 1'b0;
    strobe(8'h60, 1'b1);
    strobe(8'h61, 1'b1);
    strobe(8'h62, 1'b1);
    wait_en("t5_req", 20);
    check("t5_cnt_before", 32'(fifo_cnt), 32'd3);
    send_busy = 1'b1;
    @(negedge clk);
    check("t5_en_done", 32'(send_en), 32'd1);
    send_busy = 1'b0;
    strobe(8'h63, 1'b1);
    check("t5_cnt_same", 32'(fifo_cnt), 32'd3);
    check("t5_en_gap", 32'(send_en), 32'd0);
    @(negedge clk);
    check("t5_next_en", 32'(send_en), 32'd1);
    check("t5_next_data", 32'(send_data), 32'h61);
    tx_mode = TX_AUTO;
    wait_idle("t5_drain", 100);

    // 6. Asynchronous reset while in DONE with 4 bytes queued
    tx_mode = TX_MANUAL;
    @(negedge clk);
    send_busy = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'(8'h70 + i), 1'b1);
    wait_en("t6_req", 20);
    send_busy = 1'b1;
    @(negedge clk);
    check("t6_cnt_before", 32'(fifo_cnt), 32'd4);
    check("t6_en_before", 32'(send_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_en_async", 32'(send_en), 32'd0);
    check("t6_empty_async", 32'(empty), 32'd1);
    check("t6_cnt_async", 32'(fifo_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    send_busy = 1'b0;
    rst_n     = 1'b1;
    any_en    = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (send_en) any_en = 1'b1;
    end
    check("t6_no_req_after_reset", 32'(any_en), 32'd0);
    check("t6_empty_after_reset", 32'(empty), 32'd1);
    tx_mode = TX_AUTO;
    strobe(8'h7E, 1'b1);
    wait_idle("t6_drain", 50);

    check("all_bytes_sent", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_loop_fifo.md
Name: uart_loop_fifo

Overview:
- Byte buffer between uart_rx and uart_tx in the UART loopback path.
- Replaces the single-byte IDLE/LOOP arbitration so back-to-back received bytes are not lost while the transmitter is busy.
- Accepts one-cycle receive strobes, stores bytes in a circular FIFO, and drains them to uart_tx through a level-held request / busy handshake.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, ≥2.
- DATA_W, 8, byte width.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- i_sys_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_recv_en  in  1  one-cycle strobe from uart_rx: i_recv_data valid.
- i_recv_data  in  DATA_W  received byte.
- o_send_en  out  1  transmit request to uart_tx, level.
- o_send_data  out  DATA_W  byte to transmit; stable while o_send_en=1.
- i_send_busy  in  1  uart_tx busy flag.
- o_fifo_cnt  out  CNT_W  current occupancy, 0..DEPTH.
- o_empty  out  1  o_fifo_cnt==0.
- o_full  out  1  o_fifo_cnt==DEPTH.
- o_overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- i_clr_ovf  in  1  one-cycle clear for o_overflow.

Behaviour:
- Clock and reset: one clock, i_sys_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset state (asynchronous): wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE.
  - Outputs: o_send_en=0, o_send_data=0, o_empty=1, o_full=0, o_overflow=0, o_fifo_cnt=0.
  - Memory contents are not reset.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Write path:
  - On a cycle with i_recv_en=1 and o_full=0: mem[wr_ptr]<=i_recv_data, wr_ptr++, count++.
  - If o_full=1, the byte is dropped and o_overflow<=1. This holds even if a pop occurs in the same cycle, because the full decision uses the registered flag.
- o_overflow:
  - Set by a dropped write, cleared by i_clr_ovf.
  - If both occur in the same cycle, set wins.
- Flags: o_empty, o_full and o_fifo_cnt are registered and derived from the next-state count.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Drain FSM, three states:
  - IDLE: if o_empty=0 and i_send_busy=0, then o_send_data<=mem[rd_ptr], o_send_en<=1, go to REQ.
  - REQ: hold o_send_en=1 and o_send_data. When i_send_busy=1, go to DONE.
  - DONE: hold o_send_en=1. When i_send_busy=0, then o_send_en<=0, rd_ptr++, count-- (pop), go to IDLE.
  - Unreachable state encodings return to IDLE with o_send_en=0.
- Pop timing: a byte is popped only on completion of its transmission, never at request time. Its slot cannot be overwritten while in flight.
- Latency: byte strobed at cycle N → o_empty=0 at N+1 → o_send_en=1 with the byte at N+2, provided i_send_busy=0 and the FIFO was empty.
- Back-to-back drain: after the DONE→IDLE transition, o_send_en is low for at least one cycle before the next request.
- Ordering: strictly FIFO; no byte is duplicated or reordered.
- No reset-free recovery is provided. A stuck i_send_busy holds the FSM in REQ or DONE indefinitely, while writes continue until full.
- Reset asserted mid-transfer:
  - o_send_en drops immediately (asynchronously).
  - Contents are discarded.
  - After reset release, nothing is sent until new bytes arrive.

Test Plan:
1. Single byte: reset, strobe 0x55 at cycle N with the tx model idle → o_send_en=1 and o_send_data=0x55 at N+2. After busy high then low, o_send_en=0, o_empty=1, o_fifo_cnt=0.
2. Burst: strobe 0x01..0x0A on consecutive cycles while the tx model holds busy for 20 cycles per byte → tx receives 0x01..0x0A in order. Peak o_fifo_cnt=9 or 10. No overflow.
3. Overflow, DEPTH=16:
   - Tx held busy; strobe 0x00..0x11 (18 bytes) → o_full=1 after 16 bytes, o_overflow=1. Only 0x00..0x0F are drained, in order.
   - i_clr_ovf pulse → o_overflow=0.
   - Clear coincident with a dropped write → o_overflow stays 1.
4. Wrap-around: push and drain 40 bytes (0x20..0x47) in interleaved bursts of 5 → pointers wrap twice and the output sequence is exactly 0x20..0x47.
5. Simultaneous push and pop: strobe a byte in the same cycle as DONE→IDLE with o_fifo_cnt=3 → o_fifo_cnt stays 3 and the next o_send_data is the oldest remaining byte.
6. Reset mid-transfer: assert i_rst_n=0 while in DONE with 4 bytes queued → o_send_en=0 with no clock edge needed. After release, o_empty=1 and no request is issued until a new strobe.
